fifo_width_packer: RTL and testbench
====================================

// Module: fifo_width_packer
// PURPOSE
//  Read-side stage directly downstream of the team's sync_fifo. Pops WIDTH-bit words using the
//  FIFO's fifo_empty / rd_en / data_out interface (data_out valid the cycle after rd_en).
//  Packs RATIO consecutive words into one RATIO*WIDTH word on a valid/ready master port.
//  Sustains one packed word every RATIO cycles when the FIFO is non-empty and m_ready stays high.
// PARAMETERS
//  WIDTH  8  FIFO word width; must match the sync_fifo WIDTH
//  RATIO  4  words per packed output word; >= 2, need not be a power of two
// PORTS
//  clk         in   1              single clock, all logic posedge
//  rst         in   1              asynchronous, active-high reset
//  fifo_empty  in   1              from sync_fifo.fifo_empty
//  fifo_rd_en  out  1              to sync_fifo.rd_en
//  fifo_data   in   WIDTH          from sync_fifo.data_out, valid the cycle after fifo_rd_en
//  m_valid     out  1              packed word valid
//  m_ready     in   1              downstream accept
//  m_data      out  WIDTH*RATIO    packed word; lane 0 (first word popped) in [WIDTH-1:0]
//  flush       in   1              PACKER_FLUSH_EN only: emit partial word
//  m_keep      out  RATIO          PACKER_FLUSH_EN only: bit i set = lane i holds valid data
// BEHAVIOUR
//  - Reset (async assert, any cycle): fifo_rd_en=0, m_valid=0, m_data=0, m_keep=0, fill=0, lane=0,
//    pend=0, state=S_FILL. An in-flight read is discarded; the FIFO pointer has already advanced, so
//    that word is lost. The system resets FIFO and packer together.
//  - Counters: fill (0..RATIO) = captured + in-flight words; lane = next capture index.
//    pend = read issued last cycle. Counter width $clog2(RATIO+1).
//  - fifo_rd_en = !fifo_empty && state==S_FILL && (fill<RATIO || (m_valid && m_ready)).
//    Combinational. Never asserted while fifo_empty, so sync_fifo's unguarded data_out read stays harmless.
//  - Capture: when pend=1, fifo_data goes to lane[lane] and lane increments.
//    When the last lane is captured, m_valid rises next cycle.
//  - Latency: first fifo_rd_en in cycle 0 -> m_valid high in cycle RATIO+1 with no stalls.
//  - Handshake: m_valid && m_ready completes a transfer. m_valid, m_data and m_keep stay stable
//    until it completes. m_valid never drops without a handshake.
//  - Handshake cycle: fill becomes (rd issued ? 1 : 0) and lane becomes 0. A read issued in that
//    same cycle lands in lane 0 of the next word, so there is no bubble.
//  - Backpressure: m_valid && !m_ready -> fifo_rd_en=0. FIFO occupancy holds.
//  - fifo_empty mid-word: partial fill is retained indefinitely, with no timeout. m_valid stays 0.
//  - Unwritten lanes of m_data read 0 after reset or after a flush.
//  - FSM: S_FILL (normal), S_DRAIN (flush: await in-flight word), S_OUT (flushed partial word held).
// CONFIGURATION
//  - Macro PACKER_FLUSH_EN defined: flush and m_keep ports exist.
//    - flush accepted only in S_FILL with fill>0 and m_valid=0; otherwise ignored (not queued).
//    - On accept: no further reads. If pend=1 -> S_DRAIN, else -> S_OUT.
//    - S_DRAIN captures the in-flight word, then -> S_OUT.
//    - S_OUT: m_valid=1, m_keep = lanes captured (LSB-contiguous), empty lanes 0. Handshake -> S_FILL.
//    - Full words: m_keep = all ones. flush with fill=RATIO is ignored, since the word completes anyway.
//  - Macro undefined: no flush/m_keep ports; S_DRAIN/S_OUT are unreachable and are optimised away.
//    Every output word is full.
// STRUCTURE
//  - Shared package stream_pkg: typedef enum logic [1:0] {S_FILL,S_DRAIN,S_OUT} packer_state_t.
//    Also holds function clog2_ceil used for counter widths.
//  - Single module; no sub-module. Lane register array and counters live inline.
// TESTING (bench instantiates sync_fifo WIDTH=8 DEPTH=16 feeding the packer, RATIO=4)
//  - Write 8'h11,22,33,44 with m_ready=1 -> one beat m_data=32'h44332211, m_valid exactly 5 cycles
//    after the first fifo_rd_en.
//  - Write 16 words 0..15 with m_ready=1 -> 4 beats, 32'h03020100 .. 32'h0F0E0D0C.
//    Beats arrive every 4 cycles with no bubble.
//  - Hold m_ready=0 after the first beat with 12 more words written -> m_valid/m_data held stable,
//    fifo_rd_en=0, FIFO keeps 12 words.
//  - Write 3 words then stop -> m_valid stays 0. Write a 4th -> 32'h{w3,w2,w1,w0} emitted.
//  - Assert rst during the 2nd read of a word -> outputs 0 next edge. After release and FIFO
//    reset, 4 fresh words give a correct beat.
//  - PACKER_FLUSH_EN: write A1,B2 and pulse flush -> m_data=32'h0000B2A1, m_keep=4'b0011.
//    Packing then resumes at lane 0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared stream types and helpers for the FIFO read-side packing stage.
package stream_pkg;

    // Packer control states; S_DRAIN/S_OUT only reachable with PACKER_FLUSH_EN.
    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } packer_state_t;

    // Ceiling log2, used to size counters that must hold the value itself.
    function automatic int unsigned clog2_ceil(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_width_packer.sv
// fifo_width_packer: pops WIDTH-bit words from a sync_fifo read port and packs
// RATIO of them into one valid/ready output word (lane 0 = first word popped).
// Optional macro PACKER_FLUSH_EN adds the flush input and m_keep output so a
// partially filled word can be emitted on demand.
module fifo_width_packer
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic [WIDTH-1:0]         fifo_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH*RATIO-1:0]   m_data
`ifdef PACKER_FLUSH_EN
   ,input  logic                     flush,
    output logic [RATIO-1:0]         m_keep
`endif
);

    localparam int unsigned CW = clog2_ceil(RATIO + 1);

    packer_state_t                 state_q, state_d;
    logic [CW-1:0]                 fill_q, fill_d;
    logic [CW-1:0]                 lane_q, lane_d;
    logic                          pend_q, pend_d;
    logic                          m_valid_q, m_valid_d;
    logic [RATIO-1:0][WIDTH-1:0]   lanes_q, lanes_d;
`ifdef PACKER_FLUSH_EN
    logic [RATIO-1:0]              keep_q, keep_d;
    logic                          flush_acc_c;
    logic [CW-1:0]                 flush_cnt_c;
`endif
    logic                          hs_c;

    // Lanes [0, n) valid, upper lanes empty.
    function automatic logic [RATIO-1:0] keep_mask(input logic [CW-1:0] n);
        logic [RATIO-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            m[i] = (CW'(i) < n);
        end
        return m;
    endfunction

    assign m_valid = m_valid_q;
    assign m_data  = lanes_q;
`ifdef PACKER_FLUSH_EN
    assign m_keep  = keep_q;
`endif

    // Next-state: read issue, lane capture, handshake and flush sequencing.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        lane_d     = lane_q;
        pend_d     = 1'b0;
        m_valid_d  = m_valid_q;
        lanes_d    = lanes_q;
        fifo_rd_en = 1'b0;
        hs_c       = m_valid_q && m_ready;
`ifdef PACKER_FLUSH_EN
        keep_d      = keep_q;
        flush_acc_c = flush && (state_q == S_FILL) && (fill_q != '0)
                      && (fill_q < CW'(RATIO)) && !m_valid_q;
        flush_cnt_c = CW'(lane_q + CW'(pend_q));
`endif

        case (state_q)
            S_FILL: begin
                fifo_rd_en = !fifo_empty && ((fill_q < CW'(RATIO)) || hs_c);
`ifdef PACKER_FLUSH_EN
                if (flush_acc_c) begin
                    fifo_rd_en = 1'b0;
                end
`endif
                pend_d = fifo_rd_en;

                // Word read last cycle is on fifo_data now.
                if (pend_q) begin
                    for (int unsigned i = 0; i < RATIO; i++) begin
                        if (lane_q == CW'(i)) begin
                            lanes_d[i] = fifo_data;
                        end
                    end
                    lane_d = CW'(lane_q + CW'(1));
                    if (lane_q == CW'(RATIO - 1)) begin
                        m_valid_d = 1'b1;
`ifdef PACKER_FLUSH_EN
                        keep_d    = '1;
`endif
                    end
                end

                // A read issued on the handshake lands in lane 0 of the next word.
                if (hs_c) begin
                    m_valid_d = 1'b0;
                    lane_d    = '0;
                    fill_d    = fifo_rd_en ? CW'(1) : '0;
                end else begin
                    fill_d = CW'(fill_q + CW'(fifo_rd_en));
                end

`ifdef PACKER_FLUSH_EN
                if (flush_acc_c) begin
                    for (int unsigned i = 0; i < RATIO; i++) begin
                        if (CW'(i) >= flush_cnt_c) begin
                            lanes_d[i] = '0;
                        end
                    end
                    if (pend_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d   = S_OUT;
                        m_valid_d = 1'b1;
                        keep_d    = keep_mask(flush_cnt_c);
                    end
                end
`endif
            end
`ifdef PACKER_FLUSH_EN
            S_DRAIN: begin
                // In-flight word was captured on the accept edge; publish the partial word.
                m_valid_d = 1'b1;
                keep_d    = keep_mask(lane_q);
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (hs_c) begin
                    m_valid_d = 1'b0;
                    lanes_d   = '0;
                    keep_d    = '0;
                    fill_d    = '0;
                    lane_d    = '0;
                    state_d   = S_FILL;
                end
            end
`endif
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FILL;
            fill_q    <= '0;
            lane_q    <= '0;
            pend_q    <= 1'b0;
            m_valid_q <= 1'b0;
            lanes_q   <= '0;
`ifdef PACKER_FLUSH_EN
            keep_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            lane_q    <= lane_d;
            pend_q    <= pend_d;
            m_valid_q <= m_valid_d;
            lanes_q   <= lanes_d;
`ifdef PACKER_FLUSH_EN
            keep_q    <= keep_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_width_packer.sv
// Bench for fifo_width_packer: behavioural sync_fifo front end, word-list
// reference model feeding a scoreboard, independent output monitor.
// Flush scenario only built when PACKER_FLUSH_EN is defined.
module tb_fifo_width_packer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned RATIO = 4;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [WIDTH*RATIO-1:0] data;
        logic [RATIO-1:0]       keep;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   fifo_empty;
    logic                   fifo_rd_en;
    logic [WIDTH-1:0]       fifo_data;
    logic                   m_valid;
    logic                   m_ready = 1'b0;
    logic [WIDTH*RATIO-1:0] m_data;
`ifdef PACKER_FLUSH_EN
    logic                   flush = 1'b0;
    logic [RATIO-1:0]       m_keep;
`endif

    logic                   wr_en = 1'b0;
    logic [WIDTH-1:0]       wr_data = '0;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] acc[$];
    beat_t            sb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_count = 0;
    int first_rd_cyc = -1;
    int first_valid_cyc = -1;

    logic                   prev_v = 1'b0;
    logic                   prev_r = 1'b0;
    logic [WIDTH*RATIO-1:0] prev_d = '0;

    always #5 clk = ~clk;

    fifo_width_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef PACKER_FLUSH_EN
       ,.flush      (flush),
        .m_keep     (m_keep)
`endif
    );

    // Behavioural sync_fifo: registered data_out one cycle after rd_en.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fifo_empty <= 1'b1;
            fifo_data  <= '0;
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
            if (wr_en && fq.size() < DEPTH) fq.push_back(wr_data);
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Reference model: every RATIO words written form one expected beat.
    task automatic model_write(input logic [WIDTH-1:0] w);
        beat_t b;
        acc.push_back(w);
        if (acc.size() == RATIO) begin
            b.data = '0;
            for (int i = 0; i < RATIO; i++) b.data[i*WIDTH +: WIDTH] = acc[i];
            b.keep = '1;
            sb.push_back(b);
            acc.delete();
        end
    endtask

    task automatic wr1(input logic [WIDTH-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        model_write(w);
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int k;
        k = 0;
        while (sb.size() != 0 && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d beats still expected, want 0", tag, sb.size());
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: protocol rules plus scoreboard comparison on each transfer.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            cyc++;
            checks++;
            if (fifo_rd_en && fifo_empty) begin
                errors++;
                $display("FAIL rd_while_empty: rd_en=1 with fifo_empty=1 at cycle %0d", cyc);
            end
            if (fifo_rd_en) begin
                rd_count++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_v && !prev_r) begin
                checks++;
                if (!m_valid || m_data !== prev_d) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%0b data=%h, required valid=1 data=%h",
                             m_valid, m_data, prev_d);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: data=%h with empty scoreboard", m_data);
                end else begin
                    e = sb.pop_front();
                    if (m_data !== e.data) begin
                        errors++;
                        $display("FAIL beat_data: got %h expected %h", m_data, e.data);
                    end
`ifdef PACKER_FLUSH_EN
                    checks++;
                    if (m_keep !== e.keep) begin
                        errors++;
                        $display("FAIL beat_keep: got %b expected %b", m_keep, e.keep);
                    end
`endif
                    if (e.keep == '1) begin
                        checks++;
                        if (fifo_rd_en !== !fifo_empty) begin
                            errors++;
                            $display("FAIL no_bubble: rd_en=%0b on handshake, expected %0b",
                                     fifo_rd_en, !fifo_empty);
                        end
                    end
                end
            end
            prev_v = m_valid;
            prev_r = m_ready;
            prev_d = m_data;
        end
    end

    initial begin
        int k;
        logic [WIDTH-1:0] w;

        // Reset state
        idle(2);
        @(negedge clk);
        check("reset_valid", 64'(m_valid), 64'd0);
        check("reset_data",  64'(m_data),  64'd0);
        check("reset_rd_en", 64'(fifo_rd_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Single beat and first-word latency
        m_ready = 1'b1;
        first_rd_cyc = -1;
        first_valid_cyc = -1;
        wr1(8'h11); wr1(8'h22); wr1(8'h33); wr1(8'h44);
        wait_drain("single", 50);
        check("latency", 64'(first_valid_cyc - first_rd_cyc), 64'(RATIO + 1));

        // Sixteen words, back to back
        for (int i = 0; i < 16; i++) wr1(WIDTH'(i));
        wait_drain("stream16", 100);

        // Backpressure: first beat held, remaining 12 words stay in FIFO
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr1(WIDTH'(8'h10 + i));
        idle(30);
        @(negedge clk);
        check("bp_valid", 64'(m_valid), 64'd1);
        check("bp_data",  64'(m_data),  64'h13121110);
        check("bp_rd_en", 64'(fifo_rd_en), 64'd0);
        check("bp_occupancy", 64'(fq.size()), 64'd12);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_drain("backpressure", 100);

        // Partial fill waits indefinitely, then completes
        wr1(8'hA0); wr1(8'hA1); wr1(8'hA2);
        idle(20);
        @(negedge clk);
        check("partial_hold", 64'(m_valid), 64'd0);
        @(posedge clk); #1;
        wr1(8'hA3);
        wait_drain("partial", 50);

        // Reset during the second read of a word
        k = rd_count;
        wr1(8'h55); wr1(8'h66);
        for (int i = 0; i < 20 && (rd_count - k) < 2; i++) @(negedge clk);
        check("rst_second_read", 64'(rd_count - k), 64'd2);
        #1;
        rst = 1'b1;
        acc.delete();
        sb.delete();
        @(posedge clk); #1;
        check("rst_mid_valid", 64'(m_valid), 64'd0);
        check("rst_mid_data",  64'(m_data),  64'd0);
        check("rst_mid_rd_en", 64'(fifo_rd_en), 64'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        wr1(8'hC1); wr1(8'hC2); wr1(8'hC3); wr1(8'hC4);
        wait_drain("after_reset", 50);

`ifdef PACKER_FLUSH_EN
        // Flush a two-word partial, then confirm packing restarts at lane 0
        begin
            beat_t b;
            wr1(8'hA1); wr1(8'hB2);
            idle(10);
            flush = 1'b1;
            acc.delete();
            b.data = 32'h0000B2A1;
            b.keep = 4'b0011;
            sb.push_back(b);
            @(posedge clk); #1;
            flush = 1'b0;
            wait_drain("flush", 50);
            wr1(8'hD0); wr1(8'hD1); wr1(8'hD2); wr1(8'hD3);
            wait_drain("post_flush", 50);
        end
`endif

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && fq.size() < DEPTH - 2) begin
                w = WIDTH'($urandom);
                wr_en   = 1'b1;
                wr_data = w;
                model_write(w);
            end else begin
                wr_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        m_ready = 1'b1;
        while (acc.size() != 0) wr1(WIDTH'($urandom));
        wait_drain("random", 400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
